// File: rtl/div_share_ctrl.sv
// Purpose : arbitrates NREQ requesters round-robin onto one shared sequential divider.
// Latency : accept t -> start t+1 -> wait from t+2; response one cycle after ready (divide-by-zero: t+1).
// Backpressure: one operation in flight, so req_ready is low outside IDLE; responses are never stalled.
//
// Ports
//   i_clk                    clock, all state on the rising edge
//   i_reset                  asynchronous reset, active-low (0 = reset)
//   i_req_valid / o_req_ready per-requester handshake; o_req_ready is a one-hot grant
//   i_req_x / i_req_y        packed operands, requester i at [i*WIDTH +: WIDTH]
//   o_rsp_valid              one-cycle pulse to the owner of the result
//   o_rsp_q/o_rsp_r/o_rsp_err result; held until the next response
//   o_busy                   high whenever the controller is not idle
//   o_div_x/o_div_y/o_div_start  operands and start pulse to the divider
//   i_div_ready/i_div_q/i_div_r  divider completion and result
module div_share_ctrl #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req_valid,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic [NREQ*WIDTH-1:0]   i_req_x,
    input  logic [NREQ*WIDTH-1:0]   i_req_y,
    output logic [NREQ-1:0]         o_rsp_valid,
    output logic [WIDTH-1:0]        o_rsp_q,
    output logic [WIDTH-1:0]        o_rsp_r,
    output logic                    o_rsp_err,
    output logic                    o_busy,
    output logic [WIDTH-1:0]        o_div_x,
    output logic [WIDTH-1:0]        o_div_y,
    output logic                    o_div_start,
    input  logic                    i_div_ready,
    input  logic [WIDTH-1:0]        i_div_q,
    input  logic [WIDTH-1:0]        i_div_r
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_owner;
    logic [WIDTH-1:0]    r_x;
    logic [WIDTH-1:0]    r_y;
    logic [CW-1:0]       r_cnt;
    logic                r_div_start;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [WIDTH-1:0]    r_rsp_q;
    logic [WIDTH-1:0]    r_rsp_r;
    logic                r_rsp_err;
    logic                r_busy;

    logic                w_grant_any;
    logic [PW-1:0]       w_grant_idx;
    logic [NREQ-1:0]     w_grant_oh;
    logic [WIDTH-1:0]    w_grant_x;
    logic [WIDTH-1:0]    w_grant_y;
    logic [NREQ-1:0]     w_owner_oh;
    logic [PW-1:0]       w_ptr_next;

    // Requester index reached k steps above base, wrapping at NREQ.
    function automatic logic [PW-1:0] wrap_idx(input int base, input int k);
        return PW'((base + k) % NREQ);
    endfunction

    // Round-robin search: first valid requester at or above the pointer.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_grant_any && i_req_valid[wrap_idx(int'(r_ptr), k)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = wrap_idx(int'(r_ptr), k);
            end
        end
    end

    assign w_grant_oh = w_grant_any ? (NREQ'(1) << w_grant_idx) : '0;
    assign w_grant_x  = i_req_x[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_grant_y  = i_req_y[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_owner_oh = NREQ'(1) << r_owner;
    assign w_ptr_next = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);

    // The grant is the only combinational output; it is masked during reset
    // so that every output reads zero while reset is held.
    assign o_req_ready = (r_state == S_IDLE && i_reset) ? w_grant_oh : '0;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_q     = r_rsp_q;
    assign o_rsp_r     = r_rsp_r;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = r_busy;
    assign o_div_x     = r_x;
    assign o_div_y     = r_y;
    assign o_div_start = r_div_start;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_div_start <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Start and response are single-cycle pulses.
            r_div_start <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_owner <= w_grant_idx;
                        r_x     <= w_grant_x;
                        r_y     <= w_grant_y;
                        r_busy  <= 1'b1;
                        if (w_grant_y == '0) begin
                            // Divide-by-zero never reaches the divider.
                            r_state     <= S_RESP;
                            r_rsp_valid <= w_grant_oh;
                            r_rsp_q     <= {WIDTH{1'b1}};
                            r_rsp_r     <= w_grant_x;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_div_start <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // r_cnt == 0 is the first WAIT cycle, where ready may
                    // still be the divider's idle indication from before start.
                    if (i_div_ready && r_cnt != '0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= w_owner_oh;
                        r_rsp_q     <= i_div_q;
                        r_rsp_r     <= i_div_r;
                        r_rsp_err   <= 1'b0;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        // TIMEOUT wait cycles elapsed: abandon the divider.
                        r_state     <= S_RESP;
                        r_rsp_valid <= w_owner_oh;
                        r_rsp_q     <= '0;
                        r_rsp_r     <= '0;
                        r_rsp_err   <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Purpose : directed self-checking bench for div_share_ctrl with a behavioural divider.
// Latency : divider model raises ready four cycles after start unless told to hang.
// Backpressure: requesters hold valid until granted and drop it right after.
module tb_div_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_q, rsp_r;
    logic        rsp_err, busy;
    logic [7:0]  div_x, div_y;
    logic        div_start;
    logic        div_ready;
    logic [7:0]  div_q, div_r;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    div_share_ctrl #(.WIDTH(8), .NREQ(4), .TIMEOUT(255)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_x     (req_x),
        .i_req_y     (req_y),
        .o_rsp_valid (rsp_valid),
        .o_rsp_q     (rsp_q),
        .o_rsp_r     (rsp_r),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy),
        .o_div_x     (div_x),
        .o_div_y     (div_y),
        .o_div_start (div_start),
        .i_div_ready (div_ready),
        .i_div_q     (div_q),
        .i_div_r     (div_r)
    );

    // Divider model: idle-ready, drops ready on start, result after 4 cycles.
    logic       hang = 1'b0;
    logic [2:0] dm_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_ready <= 1'b1;
            dm_cnt    <= '0;
            div_q     <= '0;
            div_r     <= '0;
        end else if (div_start) begin
            div_ready <= 1'b0;
            dm_cnt    <= 3'd3;
            div_q     <= (div_y != 0) ? div_x / div_y : 8'h00;
            div_r     <= (div_y != 0) ? div_x % div_y : 8'h00;
        end else if (dm_cnt != 0) begin
            dm_cnt <= dm_cnt - 3'd1;
            if (dm_cnt == 3'd1 && !hang) div_ready <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[i*8 +: 8] = x;
        req_y[i*8 +: 8] = y;
        req_valid[i]    = 1'b1;
    endtask

    // Waits for the next grant, then for its response, checking both.
    task automatic complete(input string tag, input int eidx,
                            input logic [7:0] ex, input logic [7:0] ey,
                            input logic [7:0] eq, input logic [7:0] er,
                            input logic eerr, input int elat, input int estarts);
        int          n = 0;
        int          lat = 0;
        int          starts = 0;
        logic        stable = 1'b1;
        logic [3:0]  g;
        #1;
        while (req_ready == 4'h0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        g = req_ready;
        check({tag, "_grant"}, g, 32'(4'h1 << eidx));
        if (g == 4'h0) return;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) req_valid = req_valid & ~g;
            if (div_start) starts++;
            if (starts > 0 && (div_x != ex || div_y != ey)) stable = 1'b0;
        end while (rsp_valid == 4'h0 && lat < 400);
        check({tag, "_rsp_valid"}, rsp_valid, 32'(4'h1 << eidx));
        check({tag, "_q"}, rsp_q, eq);
        check({tag, "_r"}, rsp_r, er);
        check({tag, "_err"}, rsp_err, eerr);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_starts"}, starts, estarts);
        if (estarts > 0) check({tag, "_div_xy_stable"}, stable, 1'b1);
        @(negedge clk);
        check({tag, "_pulse_end"}, {busy, rsp_valid}, 5'h0);
        check({tag, "_q_hold"}, rsp_q, eq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic flag;
        #1;
        check("reset_ctrl", {busy, div_start, rsp_err, rsp_valid, req_ready}, 11'h0);
        check("reset_data", {rsp_q, rsp_r, div_x, div_y}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single operation, then a second one from another requester.
        set_req(0, 8'd45, 8'd23);
        complete("t1", 0, 8'd45, 8'd23, 8'd1, 8'd22, 1'b0, 6, 1);
        set_req(2, 8'd7, 8'd2);
        complete("t2", 2, 8'd7, 8'd2, 8'd3, 8'd1, 1'b0, 6, 1);

        // Divide by zero bypasses the divider.
        set_req(1, 8'd9, 8'd0);
        complete("t4_div0", 1, 8'd9, 8'd0, 8'hFF, 8'd9, 1'b1, 1, 0);

        // Hung divider times out after 255 wait cycles, then service resumes.
        hang = 1'b1;
        set_req(3, 8'd100, 8'd7);
        complete("t5_timeout", 3, 8'd100, 8'd7, 8'd0, 8'd0, 1'b1, 257, 1);
        hang = 1'b0;
        set_req(0, 8'd200, 8'd9);
        complete("t5_after", 0, 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 6, 1);

        // Reset while waiting on the divider.
        hang = 1'b1;
        set_req(1, 8'd50, 8'd5);
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_ctrl", {busy, div_start, rsp_err, rsp_valid, req_ready}, 11'h0);
        check("t6_rst_q", rsp_q, 8'd0);
        check("t6_rst_r", rsp_r, 8'd0);
        check("t6_rst_div_xy", {div_x, div_y}, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        hang = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid != 4'h0 || busy) flag = 1'b1;
        end
        check("t6_no_rsp_after_reset", flag, 1'b0);
        set_req(2, 8'd50, 8'd5);
        complete("t6_after", 2, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 6, 1);

        // Round-robin from a fresh reset, all four requesting together.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_req(0, 8'd10, 8'd3);
        set_req(1, 8'd20, 8'd6);
        set_req(2, 8'd255, 8'd16);
        set_req(3, 8'd99, 8'd10);
        complete("t3_r0", 0, 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 6, 1);
        complete("t3_r1", 1, 8'd20, 8'd6, 8'd3, 8'd2, 1'b0, 6, 1);
        complete("t3_r2", 2, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 6, 1);
        complete("t3_r3", 3, 8'd99, 8'd10, 8'd9, 8'd9, 1'b0, 6, 1);
        set_req(1, 8'd17, 8'd4);
        set_req(3, 8'd64, 8'd8);
        complete("t3_wrap1", 1, 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 6, 1);
        complete("t3_wrap3", 3, 8'd64, 8'd8, 8'd8, 8'd0, 1'b0, 6, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
